// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button event controller: the debounce state
// encoding and the default cycle counts (sized for a 50 MHz clock: 10 ms
// debounce, 1 s long-press, 200 ms auto-repeat).
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int DEF_DEBOUNCE_CYC = 500000;
  localparam int DEF_LONG_CYC     = 50000000;
  localparam int DEF_REPEAT_CYC   = 10000000;
  localparam int DEF_CNT_W        = 26;

endpackage

// File: rtl/btn_debounce_fsm.sv
// ---------------------------------------------------------------------------
// btn_debounce_fsm
// Synchronizes the raw button level and filters contact bounce. A level
// change is accepted only after the synchronized input has held the new
// level long enough for the debounce timer to expire.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   noisy_in   in   raw asynchronous button level, 1 = pressed
//   debounced  out  filtered level (registered), 1 in PRESSED/RELEASE_WAIT
// ---------------------------------------------------------------------------
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy_in,
  output logic debounced
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_in;
  deb_state_e       state;
  logic [CNT_W-1:0] timer;
  logic             timer_done;

  assign timer_done = (timer == TIMER_LAST);

  // stage 0/1: two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync_p0 <= noisy_in;
      sync_in <= sync_p0;
    end
  end

  // debounce FSM; debounced is updated on the transitions that cross
  // between the released pair (IDLE/PRESS_WAIT) and the pressed pair
  // (PRESSED/RELEASE_WAIT), so it is a clean registered copy of the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      debounced <= 1'b0;
    end else begin
      timer <= ((state == IDLE) || (state == PRESSED)) ? '0 : timer + CNT_W'(1);
      case (state)
        IDLE: begin
          if (sync_in) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!sync_in) begin
            state <= IDLE;
          end else if (timer_done) begin
            state     <= PRESSED;
            debounced <= 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_in) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (sync_in) begin
            state <= PRESSED;
          end else if (timer_done) begin
            state     <= IDLE;
            debounced <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          debounced <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
// Turns a bouncing push-button into clean events: press/release strobes,
// a long-press strobe after LONG_CYC cycles of hold, and auto-repeat
// strobes every REPEAT_CYC cycles while the long press continues.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   noisy_in       in   raw asynchronous button level, 1 = pressed
//   enable         in   event generation enable (debouncing always runs)
//   debounced      out  filtered button level
//   press_pulse    out  one-cycle strobe, cycle after debounced rises
//   release_pulse  out  one-cycle strobe, cycle after debounced falls
//   long_pulse     out  one-cycle strobe when the hold reaches LONG_CYC
//   repeat_pulse   out  one-cycle strobe every REPEAT_CYC after long_pulse
//   held_long      out  high from the cycle after long_pulse until release
// ---------------------------------------------------------------------------
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy_in,
  input  logic enable,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held_long
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  logic             debounced_p1;
  logic             press_p1;
  logic             release_p1;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;

  btn_debounce_fsm #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy_in  (noisy_in),
    .debounced (debounced)
  );

  // Edge strobes are registered; the final AND with enable makes a
  // disable take effect in the very cycle it is applied.
  assign press_pulse   = press_p1 & enable;
  assign release_pulse = release_p1 & enable;

  // hold_cnt counts cycles already held, so it equals LONG_CYC-1 exactly in
  // the LONG_CYC-th cycle of the hold. Gating by debounced suppresses the
  // strobe when the release lands on the threshold cycle; gating by press
  // keeps the pulses mutually exclusive for the shortest legal LONG_CYC.
  assign long_pulse   = enable & debounced & ~held_long & ~press_p1 &
                        (hold_cnt == LONG_LAST);
  assign repeat_pulse = enable & debounced & held_long &
                        (rep_cnt == REPEAT_LAST);

  // stage 1: edge detection and hold/repeat tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_p1 <= 1'b0;
      press_p1     <= 1'b0;
      release_p1   <= 1'b0;
      held_long    <= 1'b0;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
    end else begin
      debounced_p1 <= debounced;
      press_p1     <= enable & debounced & ~debounced_p1;
      release_p1   <= enable & ~debounced & debounced_p1;
      held_long    <= enable & debounced & (held_long | long_pulse);

      if (!debounced || !enable) begin
        hold_cnt <= '0;
      end else if (!held_long) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end

      if (long_pulse || !held_long) begin
        rep_cnt <= '0;
      end else if (rep_cnt == REPEAT_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_event_ctrl
// Directed scenarios plus randomized button activity, checked every cycle
// against a behavioural model: the filtered level flips once the sampled
// input has disagreed with it for DEBOUNCE_CYC+1 consecutive cycles, and the
// long/repeat events are derived arithmetically from the length of the
// current enabled hold.
// ---------------------------------------------------------------------------
module tb_button_event_ctrl;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int R  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic noisy_in;
  logic enable;
  logic debounced;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held_long;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .noisy_in      (noisy_in),
    .enable        (enable),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held_long     (held_long)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, $signed(got), $signed(exp));
    end
  endtask

  // behavioural model state
  logic m_n0, m_n1;       // input seen one and two cycles ago
  logic m_lvl;            // accepted button level
  int   m_opp;            // consecutive samples disagreeing with m_lvl
  logic m_deb_prev;
  int   m_run_prev;       // length of the enabled hold ending last cycle
  logic m_pend_press, m_pend_rel;

  // observation of the DUT for the directed timing checks
  logic mon_deb;
  int   rise_cyc, press_cyc, long_cyc;
  int   rep_q[$];

  task automatic model_reset();
    m_n0 = 1'b0; m_n1 = 1'b0; m_lvl = 1'b0; m_opp = 0;
    m_deb_prev = 1'b0; m_run_prev = 0;
    m_pend_press = 1'b0; m_pend_rel = 1'b0;
  endtask

  task automatic mon_clear();
    rise_cyc = -1000; press_cyc = -1000; long_cyc = -1000;
    rep_q.delete();
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the
  // model at the rising edge.
  task automatic step(input logic nin, input logic en);
    logic e_press, e_rel, e_long, e_held, e_rep;
    int   run_cur;
    noisy_in = nin;
    enable   = en;
    @(negedge clk);
    e_press = m_pend_press & en;
    e_rel   = m_pend_rel & en;
    e_long  = m_lvl & en & (m_run_prev == L - 1);
    e_held  = (m_run_prev >= L);
    e_rep   = e_held & m_lvl & en & (((m_run_prev - L) % R) == R - 1);
    check_eq("debounced", debounced, m_lvl);
    check_eq("press_pulse", press_pulse, e_press);
    check_eq("release_pulse", release_pulse, e_rel);
    check_eq("long_pulse", long_pulse, e_long);
    check_eq("repeat_pulse", repeat_pulse, e_rep);
    check_eq("held_long", held_long, e_held);
    check_eq("pulse_onehot",
             ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse) +
               int'(repeat_pulse)) <= 1), 1);
    if (debounced && !mon_deb) rise_cyc = cyc;
    if (press_pulse) press_cyc = cyc;
    if (long_pulse) long_cyc = cyc;
    if (repeat_pulse) rep_q.push_back(cyc);
    mon_deb = debounced;
    @(posedge clk);
    run_cur      = (m_lvl && en) ? m_run_prev + 1 : 0;
    m_pend_press = en && m_lvl && !m_deb_prev;
    m_pend_rel   = en && !m_lvl && m_deb_prev;
    m_deb_prev   = m_lvl;
    m_run_prev   = run_cur;
    if (m_n1 == m_lvl) begin
      m_opp = 0;
    end else begin
      m_opp++;
      if (m_opp == D + 1) begin
        m_lvl = ~m_lvl;
        m_opp = 0;
      end
    end
    m_n1 = m_n0;
    m_n0 = nin;
    cyc++;
    #1;
  endtask

  task automatic steps(input int n, input logic nin, input logic en);
    for (int i = 0; i < n; i++) step(nin, en);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_debounced"}, debounced, 0);
    check_eq({tag, "_press"}, press_pulse, 0);
    check_eq({tag, "_release"}, release_pulse, 0);
    check_eq({tag, "_long"}, long_pulse, 0);
    check_eq({tag, "_repeat"}, repeat_pulse, 0);
    check_eq({tag, "_held_long"}, held_long, 0);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic reset_mid(input logic nin);
    #3;
    reset_n  = 1'b0;
    noisy_in = nin;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    mon_deb = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    int reen_cyc;
    int in_cyc;
    int lat;
    logic lvl, en, nin;
    int len;

    reset_n  = 1'b0;
    noisy_in = 1'b0;
    enable   = 1'b0;
    mon_deb  = 1'b0;
    model_reset();
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_init");
    reset_n = 1'b1;

    // fast chatter never settles
    for (int i = 0; i < 30; i++) step(((i / 2) % 2) == 1, 1'b1);
    steps(10, 1'b0, 1'b1);

    // clean press, long hold with repeats, release
    mon_clear();
    in_cyc = cyc;
    steps(65, 1'b1, 1'b1);
    lat = rise_cyc - in_cyc;
    check_eq("deb_latency_window", (lat >= 6) && (lat <= 8), 1);
    check_eq("press_after_deb", press_cyc - rise_cyc, 1);
    check_eq("long_ofs", long_cyc - rise_cyc, 19);
    for (int i = 0; i < 4; i++)
      check_eq("repeat_ofs", (i < rep_q.size()) ? rep_q[i] - rise_cyc : -1, 27 + 8 * i);
    steps(20, 1'b0, 1'b1);

    // single-cycle glitch low during a hold
    mon_clear();
    steps(15, 1'b1, 1'b1);
    step(1'b0, 1'b1);
    steps(30, 1'b1, 1'b1);
    check_eq("glitch_long_ofs", long_cyc - rise_cyc, 19);
    steps(20, 1'b0, 1'b1);

    // disable mid-hold, then re-enable: hold count restarts
    mon_clear();
    steps(17, 1'b1, 1'b1);
    steps(15, 1'b1, 1'b0);
    reen_cyc = cyc;
    steps(40, 1'b1, 1'b1);
    check_eq("reenable_long_ofs", long_cyc - reen_cyc, 19);
    steps(20, 1'b0, 1'b1);

    // reset while pressed, button released during reset
    steps(14, 1'b1, 1'b1);
    reset_mid(1'b0);
    steps(20, 1'b0, 1'b1);

    // randomized activity
    lvl = 1'b0;
    while (cyc < 2200) begin
      lvl = ~lvl;
      len = $urandom_range(1, 70);
      en  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < len; i++) begin
        nin = ($urandom_range(0, 24) == 0) ? ~lvl : lvl;
        step(nin, ($urandom_range(0, 59) == 0) ? ~en : en);
      end
      if ($urandom_range(0, 29) == 0) reset_mid($urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
